// File: rtl/tcnt_apb_slave_mem_if.sv
// APB4 bus bundle between a requester (master) and the tcnt_apb_slave_mem completer (slave).
`timescale 1ns/1ps
interface tcnt_apb_slave_mem_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] paddr;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [2:0]            pprot;
   logic [STRB_WIDTH-1:0] pstrb;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pprot, pstrb, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pprot, pstrb, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/tcnt_apb_slave_mem.sv
// APB4 completer: word-addressed memory with fixed wait states, byte strobes and error responses.
// Optional macro TCNT_APB_SLV_PROT_CHECK_EN rejects unprivileged (pprot[0]=0) writes.
`timescale 1ns/1ps
module tcnt_apb_slave_mem #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                      pclk,
   input  logic                      prstn,
   tcnt_apb_slave_mem_if.slave       apb,
   output logic [7:0]                err_cnt
);
   localparam int OFF_W = $clog2(STRB_WIDTH);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt;
   logic                    wr_q, err_q;
   logic [IDX_W-1:0]        idx_q;
   logic [STRB_WIDTH-1:0]   strb_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    setup, req_err;
   logic [31:0]             widx;

   assign setup = apb.psel & ~apb.penable;
   assign widx  = 32'(apb.paddr >> OFF_W);

   // Error is decided at setup so the response path only sees registered state.
   always_comb begin
      req_err = (apb.paddr[OFF_W-1:0] != '0) || (widx >= 32'(DEPTH));
`ifdef TCNT_APB_SLV_PROT_CHECK_EN
      req_err = req_err || (apb.pwrite && !apb.pprot[0]);
`endif
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (setup) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         S_WAIT: begin
            if (!apb.psel)     state_nxt = S_IDLE;
            else if (cnt == 1) state_nxt = S_RESP;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      apb.pready  = (state == S_RESP);
      apb.pslverr = (state == S_RESP) && err_q;
      apb.prdata  = '0;
      if (state == S_RESP && !err_q && !wr_q) apb.prdata = mem[idx_q];
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         cnt     <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         strb_q  <= '0;
         wdata_q <= '0;
         err_cnt <= '0;
      end else begin
         if (state == S_IDLE && setup) begin
            cnt     <= 4'(WAIT_CYCLES);
            wr_q    <= apb.pwrite;
            err_q   <= req_err;
            idx_q   <= widx[IDX_W-1:0];
            strb_q  <= apb.pstrb;
            wdata_q <= apb.pwdata;
         end else if (state == S_WAIT && apb.psel) begin
            cnt <= cnt - 4'd1;
         end
         if (state == S_RESP && err_q && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == S_RESP && wr_q && !err_q) begin
         for (int b = 0; b < STRB_WIDTH; b++)
            if (strb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
   end
endmodule

// File: tb/tb_tcnt_apb_slave_mem.sv
// Scoreboard bench: two completers (WAIT_CYCLES=2 and 0) share a stimulus bus, each with its own psel.
`timescale 1ns/1ps
module tb_tcnt_apb_slave_mem;
   logic        pclk = 1'b0;
   logic        prstn;
   logic [15:0] paddr;
   logic [1:0]  psel;
   logic        penable, pwrite;
   logic [2:0]  pprot;
   logic [3:0]  pstrb;
   logic [31:0] pwdata;
   logic [7:0]  err_cnt0, err_cnt1;

   always #5 pclk = ~pclk;

   tcnt_apb_slave_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
   tcnt_apb_slave_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();

   assign bus0.paddr = paddr;   assign bus1.paddr = paddr;
   assign bus0.psel = psel[0];  assign bus1.psel = psel[1];
   assign bus0.penable = penable; assign bus1.penable = penable;
   assign bus0.pwrite = pwrite; assign bus1.pwrite = pwrite;
   assign bus0.pprot = pprot;   assign bus1.pprot = pprot;
   assign bus0.pstrb = pstrb;   assign bus1.pstrb = pstrb;
   assign bus0.pwdata = pwdata; assign bus1.pwdata = pwdata;

   tcnt_apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) dut0 (
      .pclk(pclk), .prstn(prstn), .apb(bus0.slave), .err_cnt(err_cnt0));
   tcnt_apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut1 (
      .pclk(pclk), .prstn(prstn), .apb(bus1.slave), .err_cnt(err_cnt1));

   typedef struct { logic [31:0] rd; logic err; } exp_t;
   exp_t q0[$], q1[$];
   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge pclk) begin
      exp_t e;
      if (bus0.pready) begin
         if (q0.size() == 0) check("dut0 unexpected pready", 32'(bus0.pready), 0);
         else begin
            e = q0.pop_front();
            check("dut0 prdata", bus0.prdata, e.rd);
            check("dut0 pslverr", 32'(bus0.pslverr), 32'(e.err));
         end
      end else if (prstn) check("dut0 pslverr without pready", 32'(bus0.pslverr), 0);
   end

   always @(negedge pclk) begin
      exp_t e;
      if (bus1.pready) begin
         if (q1.size() == 0) check("dut1 unexpected pready", 32'(bus1.pready), 0);
         else begin
            e = q1.pop_front();
            check("dut1 prdata", bus1.prdata, e.rd);
            check("dut1 pslverr", 32'(bus1.pslverr), 32'(e.err));
         end
      end else if (prstn) check("dut1 pslverr without pready", 32'(bus1.pslverr), 0);
   end

   // Called at posedge+1; returns at posedge+1 so the next setup follows with no gap.
   task automatic xfer(input int d, input logic [15:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] s, input logic [2:0] pr,
                       input logic [31:0] erd, input logic eerr, input int elat);
      exp_t e;
      int   lat;
      bit   done;
      e.rd = erd; e.err = eerr;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      paddr = a; pwrite = w; pwdata = wd; pstrb = s; pprot = pr;
      psel = '0; psel[d] = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      // Scramble the bus: the completer must work from its captured setup values.
      paddr = ~a; pwrite = ~w; pwdata = ~wd; pstrb = ~s; pprot = ~pr;
      lat = 0; done = 0;
      while (!done && lat < 40) begin
         @(negedge pclk);
         lat++;
         if ((d == 0) ? bus0.pready : bus1.pready) done = 1;
         else begin @(posedge pclk); #1; end
      end
      check($sformatf("dut%0d latency @%h", d, a), 32'(lat), 32'(elat));
      @(posedge pclk); #1;
      psel = '0; penable = 1'b0;
   endtask

   initial begin
      prstn = 1'b0; psel = '0; penable = 0; pwrite = 0; paddr = '0;
      pprot = '0; pstrb = '0; pwdata = '0;
      repeat (2) @(negedge pclk);
      check("reset prdata", bus0.prdata, 0);
      check("reset pready", 32'(bus0.pready), 0);
      check("reset pslverr", 32'(bus0.pslverr), 0);
      check("reset err_cnt", 32'(err_cnt0), 0);
      @(posedge pclk); #1 prstn = 1'b1;
      @(posedge pclk); #1;

      xfer(0, 16'h0010, 0, 32'h0,        4'hF, 3'b000, 32'h0,        0, 3);
      xfer(0, 16'h0008, 1, 32'hA5A51234, 4'h5, 3'b001, 32'h0,        0, 3);
      xfer(0, 16'h0008, 0, 32'h0,        4'h0, 3'b000, 32'h00A50034, 0, 3);
      xfer(0, 16'h0100, 1, 32'hFFFFFFFF, 4'hF, 3'b001, 32'h0,        1, 3);
      xfer(0, 16'h0002, 0, 32'h0,        4'hF, 3'b000, 32'h0,        1, 3);
      check("err_cnt after two errors", 32'(err_cnt0), 2);
      xfer(0, 16'h0008, 0, 32'h0,        4'h0, 3'b000, 32'h00A50034, 0, 3);
      xfer(0, 16'h00FC, 1, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0,        0, 3);
      xfer(0, 16'h00FC, 0, 32'h0,        4'h0, 3'b000, 32'hCAFEF00D, 0, 3);
      xfer(0, 16'h000C, 1, 32'h11112222, 4'hF, 3'b001, 32'h0,        0, 3);

      // Aborted write: psel dropped after one wait cycle.
      paddr = 16'h000C; pwrite = 1; pwdata = 32'hDEADBEEF; pstrb = 4'hF; pprot = 3'b001;
      psel = 2'b01; penable = 0;
      @(posedge pclk); #1 penable = 1;
      @(posedge pclk); #1 psel = '0; penable = 0;
      repeat (4) @(posedge pclk); #1;
      xfer(0, 16'h000C, 0, 32'h0,        4'h0, 3'b000, 32'h11112222, 0, 3);
      check("err_cnt after abort", 32'(err_cnt0), 2);

      xfer(0, 16'h000C, 1, 32'hFFFFFFFF, 4'h0, 3'b001, 32'h0,        0, 3);
      xfer(0, 16'h000C, 0, 32'h0,        4'h0, 3'b000, 32'h11112222, 0, 3);

      // penable without a setup phase must not start a transfer.
      paddr = 16'h000C; pwrite = 1; pwdata = 32'h0BAD0BAD; pstrb = 4'hF; pprot = 3'b001;
      psel = 2'b01; penable = 1;
      repeat (3) @(posedge pclk); #1;
      psel = '0; penable = 0;
      @(posedge pclk); #1;
      xfer(0, 16'h000C, 0, 32'h0,        4'h0, 3'b000, 32'h11112222, 0, 3);

`ifdef TCNT_APB_SLV_PROT_CHECK_EN
      xfer(0, 16'h0000, 1, 32'h00000055, 4'hF, 3'b000, 32'h0,        1, 3);
      xfer(0, 16'h0000, 0, 32'h0,        4'h0, 3'b000, 32'h0,        0, 3);
      check("err_cnt after prot error", 32'(err_cnt0), 3);
`else
      xfer(0, 16'h0000, 1, 32'h00000055, 4'hF, 3'b000, 32'h0,        0, 3);
      xfer(0, 16'h0000, 0, 32'h0,        4'h0, 3'b000, 32'h00000055, 0, 3);
      check("err_cnt prot ignored", 32'(err_cnt0), 2);
`endif
      xfer(0, 16'h0000, 1, 32'h00000077, 4'hF, 3'b001, 32'h0,        0, 3);
      xfer(0, 16'h0000, 0, 32'h0,        4'h0, 3'b000, 32'h00000077, 0, 3);

      // Zero wait states, back-to-back.
      xfer(1, 16'h0004, 1, 32'h00000001, 4'hF, 3'b001, 32'h0,        0, 1);
      xfer(1, 16'h0004, 0, 32'h0,        4'h0, 3'b000, 32'h00000001, 0, 1);
      check("dut1 err_cnt clean", 32'(err_cnt1), 0);

      for (int i = 0; i < 254; i++)
         xfer(1, 16'h0001, 0, 32'h0, 4'h0, 3'b000, 32'h0, 1, 1);
      check("dut1 err_cnt 254", 32'(err_cnt1), 254);
      for (int i = 0; i < 3; i++)
         xfer(1, 16'h0400, 1, 32'h1, 4'hF, 3'b001, 32'h0, 1, 1);
      check("dut1 err_cnt saturated", 32'(err_cnt1), 255);
      xfer(1, 16'h0004, 0, 32'h0,        4'h0, 3'b000, 32'h00000001, 0, 1);

      repeat (3) @(posedge pclk);
      check("dut0 scoreboard drained", 32'(q0.size()), 0);
      check("dut1 scoreboard drained", 32'(q1.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
